// File: rtl/uart_rx_deserializer_if.sv
// Serial-in / byte-out bundle between the UART receiver and the frame-collection logic.
// The receiver takes the master view; the byte consumer (and the line driver) the slave view.
interface uart_rx_deserializer_if;
   logic       uart_rx_d_in;
   logic [7:0] uart_received_data;
   logic       uart_rx_valid;
   logic       uart_rx_frame_err;
   logic       uart_rx_busy;

   modport master (
      input  uart_rx_d_in,
      output uart_received_data,
      output uart_rx_valid,
      output uart_rx_frame_err,
      output uart_rx_busy
   );

   modport slave (
      output uart_rx_d_in,
      input  uart_received_data,
      input  uart_rx_valid,
      input  uart_rx_frame_err,
      input  uart_rx_busy
   );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 LSB-first UART receiver without oversampling: one bit-period counter samples
// every bit at its centre and emits a byte with a one-cycle valid or frame-error pulse.
module uart_rx_deserializer #(
   parameter logic [27:0] CLOCK_FREQ = 28'd50000000,
   parameter logic [23:0] BAUD_RATE  = 24'd4000000
) (
   input  logic                    clk,
   input  logic                    reset,
   uart_rx_deserializer_if.master  rx_if
);

   localparam int unsigned CLKS_PER_BIT = 32'(CLOCK_FREQ / {4'd0, BAUD_RATE});
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_baud
         $error("uart_rx_deserializer: CLOCK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic             rst_meta_q, rst_meta_d;
   logic             rst_sync_q, rst_sync_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             rx_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             busy;

   // Reset asserts immediately but releases two clocks later, in step with clk.
   always_comb begin
      rst_meta_d = 1'b1;
      rst_sync_d = rst_meta_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= rst_meta_d;
         rst_sync_q <= rst_sync_d;
      end
   end

   always_comb begin
      sync1_d = rx_if.uart_rx_d_in;
      sync2_d = sync1_q;
   end

   assign rx_s = sync2_q;

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            // A start bit that is high again at its centre was only a glitch.
            if (cnt_q == CNT_HALF_END) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_BIT_END) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = '0;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_BIT_END) begin
               cnt_d   = '0;
               state_d = rx_s ? S_IDLE : S_BREAK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BREAK: begin
            // Wait out a held-low line so it is not read as repeated start bits.
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if ((state_q == S_STOP) && (cnt_q == CNT_BIT_END)) begin
         if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ferr_d = 1'b1;
         end
      end
      busy = (state_q != S_IDLE);
   end

   assign rx_if.uart_received_data = data_q;
   assign rx_if.uart_rx_valid      = valid_q;
   assign rx_if.uart_rx_frame_err  = ferr_q;
   assign rx_if.uart_rx_busy       = busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: serial frames are driven onto two receivers (4 Mbaud and 115200 baud)
// while a monitor pops the expected byte/error outcome for every pulse the receivers emit.
module tb_uart_rx_deserializer;

   localparam int CPB_A   = 50000000 / 4000000;
   localparam int CPB_B   = 50000000 / 115200;
   localparam int LAT_NOM = 2 + CPB_A / 2 + 9 * CPB_A;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic line_a = 1'b1;
   logic line_b = 1'b1;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   last_valid_cyc_a = 0;
   logic [7:0] last_good_a = 8'h00;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   uart_rx_deserializer_if if_a ();
   uart_rx_deserializer_if if_b ();

   assign if_a.uart_rx_d_in = line_a;
   assign if_b.uart_rx_d_in = line_b;

   uart_rx_deserializer #(
      .CLOCK_FREQ (28'd50000000),
      .BAUD_RATE  (24'd4000000)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .rx_if (if_a.master)
   );

   uart_rx_deserializer #(
      .CLOCK_FREQ (28'd50000000),
      .BAUD_RATE  (24'd115200)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .rx_if (if_b.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor for both receivers.
   always @(negedge clk) begin
      if (if_a.uart_rx_valid || if_a.uart_rx_frame_err) begin
         check("a_pulse_exclusive", 32'(if_a.uart_rx_valid & if_a.uart_rx_frame_err), 32'd0);
         check("a_pulse_spacing", 32'(prev_a), 32'd0);
         if (if_a.uart_rx_valid) begin
            check("a_busy_with_valid", 32'(if_a.uart_rx_busy), 32'd0);
            last_valid_cyc_a = cyc;
         end
         if (qa.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_unexpected_pulse: got valid=%0b err=%0b data=0x%0h, required no pulse",
                     if_a.uart_rx_valid, if_a.uart_rx_frame_err, if_a.uart_received_data);
         end else begin
            ea = qa.pop_front();
            check("a_pulse_kind", 32'(if_a.uart_rx_frame_err), 32'(ea.is_err));
            check("a_data", 32'(if_a.uart_received_data), 32'(ea.data));
         end
      end
      prev_a = if_a.uart_rx_valid | if_a.uart_rx_frame_err;

      if (if_b.uart_rx_valid || if_b.uart_rx_frame_err) begin
         check("b_pulse_exclusive", 32'(if_b.uart_rx_valid & if_b.uart_rx_frame_err), 32'd0);
         check("b_pulse_spacing", 32'(prev_b), 32'd0);
         if (qb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL b_unexpected_pulse: got valid=%0b err=%0b data=0x%0h, required no pulse",
                     if_b.uart_rx_valid, if_b.uart_rx_frame_err, if_b.uart_received_data);
         end else begin
            eb = qb.pop_front();
            check("b_pulse_kind", 32'(if_b.uart_rx_frame_err), 32'(eb.is_err));
            check("b_data", 32'(if_b.uart_received_data), 32'(eb.data));
         end
      end
      prev_b = if_b.uart_rx_valid | if_b.uart_rx_frame_err;
   end

   task automatic set_line(input bit which, input logic v);
      if (which) line_b = v;
      else       line_a = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame; gmask flips chosen data bits for one clock early in the bit.
   task automatic send_frame(input bit which, input logic [7:0] b, input int clks,
                             input logic stop_v, input logic [7:0] gmask);
      set_line(which, 1'b0);
      idle(clks);
      for (int i = 0; i < 8; i++) begin
         set_line(which, b[i]);
         if (gmask[i]) begin
            idle(2);
            set_line(which, ~b[i]);
            idle(1);
            set_line(which, b[i]);
            idle(clks - 3);
         end else begin
            idle(clks);
         end
      end
      set_line(which, stop_v);
      idle(clks);
   endtask

   task automatic expect_good_a(input logic [7:0] b);
      qa.push_back(exp_t'{is_err: 1'b0, data: b});
      last_good_a = b;
   endtask

   task automatic expect_err_a();
      qa.push_back(exp_t'{is_err: 1'b1, data: last_good_a});
   endtask

   initial begin
      int         lat;
      int         t0;
      logic [7:0] b;
      logic       stop_ok;

      // Reset state
      reset = 1'b0;
      idle(3);
      check("rst_data", 32'(if_a.uart_received_data), 32'h00);
      check("rst_valid", 32'(if_a.uart_rx_valid), 32'd0);
      check("rst_frame_err", 32'(if_a.uart_rx_frame_err), 32'd0);
      check("rst_busy", 32'(if_a.uart_rx_busy), 32'd0);
      reset = 1'b1;
      idle(5);

      // Single byte and latency
      expect_good_a(8'hA5);
      t0 = cyc;
      send_frame(1'b0, 8'hA5, CPB_A, 1'b1, 8'h00);
      idle(3 * CPB_A);
      check("t1_drained", 32'(qa.size()), 32'd0);
      lat = last_valid_cyc_a - (t0 + 1);
      n_cmp++;
      if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
         n_err++;
         $display("FAIL t1_latency: got %0d cycles, required %0d +/-1", lat, LAT_NOM);
      end

      // Back-to-back frames with no idle gap
      for (int i = 0; i < 16; i++) begin
         expect_good_a(8'(i));
         send_frame(1'b0, 8'(i), CPB_A, 1'b1, 8'h00);
      end
      idle(3 * CPB_A);
      check("t2_drained", 32'(qa.size()), 32'd0);

      // Short low glitch on an idle line
      line_a = 1'b0;
      idle(3);
      line_a = 1'b1;
      idle(4 * CPB_A);
      check("t3_data_held", 32'(if_a.uart_received_data), 32'(last_good_a));
      check("t3_busy", 32'(if_a.uart_rx_busy), 32'd0);

      // Low stop bit, held-low line, then a good frame
      expect_err_a();
      send_frame(1'b0, 8'h3C, CPB_A, 1'b0, 8'h00);
      idle(40);
      check("t4_busy_in_break", 32'(if_a.uart_rx_busy), 32'd1);
      line_a = 1'b1;
      idle(2 * CPB_A);
      check("t4_err_drained", 32'(qa.size()), 32'd0);
      check("t4_data_kept", 32'(if_a.uart_received_data), 32'h0F);
      expect_good_a(8'h7E);
      send_frame(1'b0, 8'h7E, CPB_A, 1'b1, 8'h00);
      idle(3 * CPB_A);
      check("t4_drained", 32'(qa.size()), 32'd0);

      // Reset in the middle of a frame
      fork
         send_frame(1'b0, 8'hFF, CPB_A, 1'b1, 8'h00);
         begin
            idle(5 * CPB_A + CPB_A / 2);
            reset = 1'b0;
            idle(3);
            check("t5_data_in_reset", 32'(if_a.uart_received_data), 32'h00);
            check("t5_busy_in_reset", 32'(if_a.uart_rx_busy), 32'd0);
            reset = 1'b1;
         end
      join
      last_good_a = 8'h00;
      idle(2 * CPB_A);
      check("t5_data_after_reset", 32'(if_a.uart_received_data), 32'h00);
      expect_good_a(8'h81);
      send_frame(1'b0, 8'h81, CPB_A, 1'b1, 8'h00);
      idle(3 * CPB_A);
      check("t5_drained", 32'(qa.size()), 32'd0);

      // Random bytes, random stop-bit errors, off-centre glitches, random gaps
      for (int i = 0; i < 40; i++) begin
         b       = 8'($urandom);
         stop_ok = ($urandom_range(0, 4) != 0);
         if (stop_ok) expect_good_a(b);
         else         expect_err_a();
         send_frame(1'b0, b, CPB_A, stop_ok, 8'($urandom) & 8'($urandom));
         if (!stop_ok) begin
            idle($urandom_range(0, 30));
            line_a = 1'b1;
            idle(2 * CPB_A);
         end
         idle($urandom_range(0, 15));
      end
      idle(3 * CPB_A);
      check("rand_drained", 32'(qa.size()), 32'd0);
      check("rand_data_final", 32'(if_a.uart_received_data), 32'(last_good_a));

      // 115200 baud with the line bit period 2% slow, then 2% fast
      qb.push_back(exp_t'{is_err: 1'b0, data: 8'h5A});
      send_frame(1'b1, 8'h5A, (CPB_B * 102 + 50) / 100, 1'b1, 8'h00);
      idle(2 * CPB_B);
      check("t6_slow_drained", 32'(qb.size()), 32'd0);
      qb.push_back(exp_t'{is_err: 1'b0, data: 8'h5A});
      send_frame(1'b1, 8'h5A, (CPB_B * 98) / 100, 1'b1, 8'h00);
      idle(2 * CPB_B);
      check("t6_fast_drained", 32'(qb.size()), 32'd0);
      check("t6_data", 32'(if_b.uart_received_data), 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
